// File: rtl/wb_initiator.sv
// wb_initiator: single-outstanding Wishbone classic initiator.
// Accepts one command on a valid/ready request port, runs exactly one
// Wishbone cycle, then presents the result on a valid/ready response port.
// A bus cycle that sees neither ack nor err within TIMEOUT cycles is aborted
// and reported as an error.
module wb_initiator #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_data_i,
   input  logic [3:0]  req_sel_i,
   input  logic        req_we_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_data_o,
   output logic        rsp_err_o,
   output logic [31:0] wbm_addr_o,
   output logic [31:0] wbm_dat_o,
   output logic [3:0]  wbm_sel_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // Last wait-count value at which the bus cycle may still complete.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        req_ready_q, req_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] wbm_addr_q, wbm_addr_d;
   logic [31:0] wbm_dat_q, wbm_dat_d;
   logic [3:0]  wbm_sel_q, wbm_sel_d;
   logic        wbm_we_q, wbm_we_d;
   logic        wbm_cyc_q, wbm_cyc_d;

   logic        bus_done;
   logic        bus_ok;

   // The Wishbone output registers double as the latched command, so they
   // only carry non-zero values while a bus cycle is in progress.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      wbm_addr_d  = wbm_addr_q;
      wbm_dat_d   = wbm_dat_q;
      wbm_sel_d   = wbm_sel_q;
      wbm_we_d    = wbm_we_q;
      wbm_cyc_d   = wbm_cyc_q;

      // Error wins over a simultaneous ack; timeout counts as an error.
      bus_done = wbm_ack_i || wbm_err_i || (cnt_q == CNT_LAST);
      bus_ok   = wbm_ack_i && !wbm_err_i;

      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               state_d     = S_BUS;
               cnt_d       = 8'd0;
               req_ready_d = 1'b0;
               wbm_cyc_d   = 1'b1;
               wbm_addr_d  = req_addr_i & 32'hFFFF_FFFC;
               wbm_dat_d   = req_data_i;
               wbm_sel_d   = req_sel_i;
               wbm_we_d    = req_we_i;
            end
         end
         S_BUS: begin
            if (bus_done) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = !bus_ok;
               rsp_data_d  = (bus_ok && !wbm_we_q) ? wbm_dat_i : 32'h0;
               wbm_cyc_d   = 1'b0;
               wbm_addr_d  = 32'h0;
               wbm_dat_d   = 32'h0;
               wbm_sel_d   = 4'h0;
               wbm_we_d    = 1'b0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready_i) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
               rsp_data_d  = 32'h0;
               rsp_err_d   = 1'b0;
               req_ready_d = 1'b1;
            end
         end
         default: begin
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
            rsp_valid_d = 1'b0;
            wbm_cyc_d   = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset abandons any transaction in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 32'h0;
         rsp_err_q   <= 1'b0;
         wbm_addr_q  <= 32'h0;
         wbm_dat_q   <= 32'h0;
         wbm_sel_q   <= 4'h0;
         wbm_we_q    <= 1'b0;
         wbm_cyc_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         wbm_addr_q  <= wbm_addr_d;
         wbm_dat_q   <= wbm_dat_d;
         wbm_sel_q   <= wbm_sel_d;
         wbm_we_q    <= wbm_we_d;
         wbm_cyc_q   <= wbm_cyc_d;
      end
   end

   assign req_ready_o = req_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_err_o   = rsp_err_q;
   assign wbm_addr_o  = wbm_addr_q;
   assign wbm_dat_o   = wbm_dat_q;
   assign wbm_sel_o   = wbm_sel_q;
   assign wbm_we_o    = wbm_we_q;
   assign wbm_cyc_o   = wbm_cyc_q;
   assign wbm_stb_o   = wbm_cyc_q;

endmodule

// File: tb/tb_wb_initiator.sv
// tb_wb_initiator: directed transactions against wb_initiator with a
// configurable Wishbone slave and a transaction-level expectation model.
module tb_wb_initiator;
   localparam int TO = 16;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [31:0] req_addr_i = 32'h0;
   logic [31:0] req_data_i = 32'h0;
   logic [3:0]  req_sel_i = 4'h0;
   logic        req_we_i = 1'b0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic [31:0] rsp_data_o;
   logic        rsp_err_o;
   logic [31:0] wbm_addr_o;
   logic [31:0] wbm_dat_o;
   logic [3:0]  wbm_sel_o;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;
   logic        wbm_err_i;

   int n_tests = 0;
   int n_fail  = 0;

   // expectation for the open transaction (written by the driver)
   logic        chk_en   = 1'b0;
   logic        txn_open = 1'b0;
   int          txn_id   = 0;
   logic [31:0] ex_addr, ex_dat, ex_rdata;
   logic [3:0]  ex_sel;
   logic        ex_we, ex_err;
   int          ex_cycles;

   // observations (written by the compare process)
   int          seen_id = 0;
   int          stb_cnt = 0;
   int          rsp_cnt = 0;
   logic [31:0] cap_addr, cap_dat, cap_rdata;
   logic [3:0]  cap_sel;
   logic        cap_we, cap_err;

   // slave behaviour
   int          cfg_delay = 0;
   logic        cfg_ack   = 1'b0;
   logic        cfg_err   = 1'b0;
   logic        cfg_noise = 1'b0;
   logic [31:0] cfg_rdata = 32'h0;
   int          slv_cnt   = 0;

   wb_initiator #(.TIMEOUT(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_addr_i(req_addr_i), .req_data_i(req_data_i),
      .req_sel_i(req_sel_i), .req_we_i(req_we_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
      .wbm_addr_o(wbm_addr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
   );

   initial forever #5 clk_i = ~clk_i;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   // slave: counts cycles of the current strobe, answers at cfg_delay
   always @(posedge clk_i) begin
      if (rst_i || !wbm_cyc_o) slv_cnt <= 0;
      else                     slv_cnt <= slv_cnt + 1;
   end

   always_comb begin
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      if (wbm_cyc_o && wbm_stb_o && slv_cnt == cfg_delay) begin
         wbm_ack_i = cfg_ack;
         wbm_err_i = cfg_err;
      end
      if (!wbm_cyc_o && cfg_noise) begin
         wbm_ack_i = 1'b1;
         wbm_err_i = 1'b1;
      end
   end

   assign wbm_dat_i = cfg_rdata;

   // compare process: checks every cycle outside reset
   always @(negedge clk_i) begin
      if (chk_en && !rst_i) begin
         if (txn_id != seen_id) begin
            seen_id = txn_id;
            stb_cnt = 0;
            rsp_cnt = 0;
         end
         if (!txn_open) begin
            chk("idle_ready", 64'(req_ready_o), 64'd1);
            chk("idle_cyc_stb", 64'({wbm_cyc_o, wbm_stb_o}), 64'd0);
            chk("idle_rsp_valid", 64'(rsp_valid_o), 64'd0);
            chk("idle_bus_zero", 64'({wbm_we_o, wbm_sel_o, wbm_dat_o}), 64'd0);
         end else begin
            chk("busy_ready", 64'(req_ready_o), 64'd0);
            if (wbm_cyc_o) begin
               chk("bus_stb", 64'(wbm_stb_o), 64'd1);
               chk("bus_no_rsp", 64'(rsp_valid_o), 64'd0);
               chk("bus_addr", 64'(wbm_addr_o), 64'(ex_addr));
               chk("bus_dat", 64'(wbm_dat_o), 64'(ex_dat));
               chk("bus_sel", 64'(wbm_sel_o), 64'(ex_sel));
               chk("bus_we", 64'(wbm_we_o), 64'(ex_we));
               chk("bus_len_max", 64'(stb_cnt < ex_cycles), 64'd1);
               chk("bus_after_rsp", 64'(rsp_cnt), 64'd0);
               stb_cnt++;
               cap_addr = wbm_addr_o;
               cap_dat  = wbm_dat_o;
               cap_sel  = wbm_sel_o;
               cap_we   = wbm_we_o;
            end else begin
               chk("rsp_stb", 64'(wbm_stb_o), 64'd0);
               chk("rsp_bus_zero", 64'({wbm_we_o, wbm_sel_o, wbm_dat_o}), 64'd0);
               chk("rsp_valid", 64'(rsp_valid_o), 64'd1);
               if (rsp_cnt == 0) chk("bus_len", 64'(stb_cnt), 64'(ex_cycles));
               chk("rsp_data", 64'(rsp_data_o), 64'(ex_rdata));
               chk("rsp_err", 64'(rsp_err_o), 64'(ex_err));
               rsp_cnt++;
               cap_rdata = rsp_data_o;
               cap_err   = rsp_err_o;
            end
         end
      end
   end

   // Build the expectation from the rules, issue one command, answer via slave.
   task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic w, input int dly, input logic ack_en, input logic err_en,
                         input logic [31:0] rd, input int hold, input logic poke);
      int n;
      int seen;
      cfg_delay = dly;
      cfg_ack   = ack_en;
      cfg_err   = err_en;
      cfg_rdata = rd;
      ex_addr = a & 32'hFFFF_FFFC;
      ex_dat  = d;
      ex_sel  = s;
      ex_we   = w;
      if ((ack_en || err_en) && dly < TO) begin
         ex_cycles = dly + 1;
         ex_err    = err_en;
      end else begin
         ex_cycles = TO;
         ex_err    = 1'b1;
      end
      ex_rdata = (!ex_err && !w) ? rd : 32'h0;
      req_addr_i  = a;
      req_data_i  = d;
      req_sel_i   = s;
      req_we_i    = w;
      req_valid_i = 1'b1;
      n = 0;
      @(negedge clk_i);
      while (!req_ready_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      if (!req_ready_o) begin
         chk("accept_bound", 64'd0, 64'd1);
         req_valid_i = 1'b0;
         return;
      end
      @(posedge clk_i);
      #1;
      txn_open = 1'b1;
      txn_id++;
      // scramble the request inputs; the latched command must not change
      req_valid_i = 1'b0;
      req_addr_i  = ~a;
      req_data_i  = ~d;
      req_sel_i   = ~s;
      req_we_i    = ~w;
      n = 0;
      seen = 0;
      while (1) begin
         @(negedge clk_i);
         if (rsp_valid_o) begin
            seen++;
            if (seen > hold) begin
               rsp_ready_i = 1'b1;
               req_valid_i = 1'b0;
               break;
            end
            if (poke) req_valid_i = 1'b1;
         end
         n++;
         if (n > 300) begin
            chk("rsp_bound", 64'd0, 64'd1);
            break;
         end
      end
      @(posedge clk_i);
      #1;
      rsp_ready_i = 1'b0;
      txn_open    = 1'b0;
      $display("[TB] txn %0d addr=%08h we=%0d stb_cycles=%0d rsp_data=%08h rsp_err=%0d",
               txn_id, a, w, stb_cnt, cap_rdata, cap_err);
   endtask

   initial begin
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      chk("reset_ready", 64'(req_ready_o), 64'd1);
      chk("reset_cyc", 64'(wbm_cyc_o), 64'd0);
      chk("reset_rsp", 64'({rsp_valid_o, rsp_err_o, rsp_data_o}), 64'd0);
      chk_en = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;

      // read, same-cycle ack
      do_txn(32'h0000_0104, 32'h0, 4'hF, 1'b0, 0, 1'b1, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
      chk("rd_stb_cycles", 64'(stb_cnt), 64'd1);
      chk("rd_addr", 64'(cap_addr), 64'h104);
      chk("rd_data", 64'(cap_rdata), 64'hDEAD_BEEF);
      chk("rd_err", 64'(cap_err), 64'd0);

      // write, unaligned address, slave data must not leak into response
      do_txn(32'h0000_0013, 32'h1122_3344, 4'b0101, 1'b1, 2, 1'b1, 1'b0, 32'hCAFE_F00D, 0, 1'b0);
      chk("wr_addr", 64'(cap_addr), 64'h10);
      chk("wr_we", 64'(cap_we), 64'd1);
      chk("wr_sel", 64'(cap_sel), 64'h5);
      chk("wr_dat", 64'(cap_dat), 64'h1122_3344);
      chk("wr_rsp_data", 64'(cap_rdata), 64'd0);
      chk("wr_err", 64'(cap_err), 64'd0);

      // slave never answers
      do_txn(32'h0000_2000, 32'h0, 4'hF, 1'b0, 0, 1'b0, 1'b0, 32'h1234_5678, 0, 1'b0);
      chk("to_stb_cycles", 64'(stb_cnt), 64'd16);
      chk("to_err", 64'(cap_err), 64'd1);
      chk("to_data", 64'(cap_rdata), 64'd0);

      // ack and err together in first bus cycle
      do_txn(32'h0000_3000, 32'h0, 4'hF, 1'b0, 0, 1'b1, 1'b1, 32'hAAAA_5555, 0, 1'b0);
      chk("ackerr_err", 64'(cap_err), 64'd1);
      chk("ackerr_data", 64'(cap_rdata), 64'd0);

      // err alone after three wait cycles
      do_txn(32'h0000_3004, 32'h0, 4'h3, 1'b0, 3, 1'b0, 1'b1, 32'h0BAD_0BAD, 0, 1'b0);
      chk("err_stb_cycles", 64'(stb_cnt), 64'd4);

      // ack in the last allowed cycle still succeeds
      do_txn(32'h0000_4008, 32'h0, 4'hF, 1'b0, TO - 1, 1'b1, 1'b0, 32'h5A5A_A5A5, 0, 1'b0);
      chk("late_ack_cycles", 64'(stb_cnt), 64'd16);
      chk("late_ack_err", 64'(cap_err), 64'd0);
      chk("late_ack_data", 64'(cap_rdata), 64'h5A5A_A5A5);

      // response back-pressure with new requests offered meanwhile
      do_txn(32'h0000_500C, 32'h0, 4'hF, 1'b0, 1, 1'b1, 1'b0, 32'h0F0F_F0F0, 5, 1'b1);
      chk("hold_valid_cycles", 64'(rsp_cnt), 64'd6);
      repeat (3) @(posedge clk_i);
      #1;

      // ack/err noise outside the bus cycle
      cfg_noise = 1'b1;
      repeat (4) @(posedge clk_i);
      #1;
      do_txn(32'h0000_6000, 32'h7777_8888, 4'b1000, 1'b1, 1, 1'b1, 1'b0, 32'h0, 0, 1'b0);
      cfg_noise = 1'b0;

      // reset pulse after three wait cycles of a stalled bus cycle
      cfg_ack = 1'b0;
      cfg_err = 1'b0;
      ex_addr = 32'h0000_7000; ex_dat = 32'h0; ex_sel = 4'hF; ex_we = 1'b0;
      ex_cycles = TO; ex_err = 1'b1; ex_rdata = 32'h0;
      req_addr_i = 32'h0000_7000; req_data_i = 32'h0; req_sel_i = 4'hF; req_we_i = 1'b0;
      req_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      txn_open = 1'b1;
      txn_id++;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b1;
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      txn_open = 1'b0;
      chk("rst_stb_cycles", 64'(stb_cnt), 64'd3);
      @(negedge clk_i);
      chk("rst_cyc_drop", 64'({wbm_cyc_o, wbm_stb_o}), 64'd0);
      chk("rst_no_rsp", 64'(rsp_valid_o), 64'd0);
      chk("rst_ready", 64'(req_ready_o), 64'd1);
      $display("[TB] txn %0d addr=00007000 aborted by reset after %0d stb cycles", txn_id, stb_cnt);
      repeat (5) @(posedge clk_i);
      #1;

      // normal operation after the abort
      do_txn(32'h0000_8000, 32'h0, 4'hF, 1'b0, 0, 1'b1, 1'b0, 32'h1357_9BDF, 0, 1'b0);
      chk("post_rst_data", 64'(cap_rdata), 64'h1357_9BDF);
      chk("post_rst_cycles", 64'(stb_cnt), 64'd1);

      repeat (2) @(posedge clk_i);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
